cdb_arbiter: RTL and testbench

- Shares the NUM_CDB common data bus ports between NUM_FU functional-unit requesters (ALUs, mult, load unit).
- Grants are round-robin, issued combinationally in the request cycle; each grant drives the FU's cdb_en.
- Granted packets are captured into a registered CDB output stage, one cycle later, for the map table, ROB and RS wakeup.
- Keeps a rotating priority pointer so that no requester starves under sustained contention.

---
 rtl/cdb_arbiter_pkg.sv | 28 ++
 rtl/cdb_arbiter_if.sv | 45 ++++
 rtl/cdb_arbiter_rr_multi_select.sv | 59 +++++
 rtl/cdb_arbiter.sv | 93 +++++++++
 tb/tb_cdb_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared types and default sizes for the common-data-bus arbiter slice.
//   cdb_reg_packet_t : one CDB broadcast packet {valid, result, completing_reg}
//   fu_idx_e         : symbolic index of each requesting functional unit
//   NUM_FU_DEF / NUM_CDB_DEF : default requester / broadcast-port counts
// ----------------------------------------------------------------------------
package cdb_arbiter_pkg;

    localparam int NUM_FU_DEF  = 4;
    localparam int NUM_CDB_DEF = 2;
    localparam int RESULT_W    = 32;
    localparam int REG_IDX_W   = 6;

    typedef struct packed {
        logic                 valid;
        logic [RESULT_W-1:0]  result;
        logic [REG_IDX_W-1:0] completing_reg;
    } cdb_reg_packet_t;

    typedef enum logic [1:0] {
        FU_ALU0 = 2'd0,
        FU_ALU1 = 2'd1,
        FU_MULT = 2'd2,
        FU_LOAD = 2'd3
    } fu_idx_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// ----------------------------------------------------------------------------
// cdb_arbiter_if
// Bundles the FU request/grant handshake and the registered CDB outputs.
//   fu_req      : per-FU request (FU -> arbiter)
//   fu_packet   : per-FU result packet, held stable while requesting
//   fu_grant    : per-FU grant, used as the FU's cdb_en (arbiter -> FU)
//   cdb_packets : registered broadcast packets (arbiter -> consumers)
//   rr_ptr      : current highest-priority FU index
//   grant_count : total grants since reset, wrapping
// Modports: master = FU/consumer side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU   = NUM_FU_DEF,
    parameter int NUM_CDB  = NUM_CDB_DEF,
    parameter int FU_IDX_W = $clog2(NUM_FU)
);

    logic            [NUM_FU-1:0]  fu_req;
    cdb_reg_packet_t [NUM_FU-1:0]  fu_packet;
    logic            [NUM_FU-1:0]  fu_grant;
    cdb_reg_packet_t [NUM_CDB-1:0] cdb_packets;
    logic            [FU_IDX_W-1:0] rr_ptr;
    logic            [31:0]         grant_count;

    modport master (
        output fu_req,
        output fu_packet,
        input  fu_grant,
        input  cdb_packets,
        input  rr_ptr,
        input  grant_count
    );

    modport slave (
        input  fu_req,
        input  fu_packet,
        output fu_grant,
        output cdb_packets,
        output rr_ptr,
        output grant_count
    );

endinterface

// File: rtl/cdb_arbiter_rr_multi_select.sv
// ----------------------------------------------------------------------------
// cdb_arbiter_rr_multi_select
// Combinational round-robin picker granting up to NUM_CDB requesters.
//   req       : request vector
//   start_ptr : index scanned first (highest priority)
//   grant     : one bit per granted requester
//   slot_idx  : FU index occupying each output slot, in scan order
//   slot_vld  : slot k is filled this cycle
//   next_ptr  : one past the last granted index (start_ptr if none)
//   grant_cnt : number of grants issued
// ----------------------------------------------------------------------------
module cdb_arbiter_rr_multi_select #(
    parameter int NUM_FU   = 4,
    parameter int NUM_CDB  = 2,
    parameter int FU_IDX_W = $clog2(NUM_FU),
    parameter int CNT_W    = $clog2(NUM_CDB + 1)
) (
    input  logic [NUM_FU-1:0]                 req,
    input  logic [FU_IDX_W-1:0]               start_ptr,
    output logic [NUM_FU-1:0]                 grant,
    output logic [NUM_CDB-1:0][FU_IDX_W-1:0]  slot_idx,
    output logic [NUM_CDB-1:0]                slot_vld,
    output logic [FU_IDX_W-1:0]               next_ptr,
    output logic [CNT_W-1:0]                  grant_cnt
);

    always_comb begin
        int                  cnt;
        logic [FU_IDX_W-1:0] idx;

        grant    = '0;
        slot_idx = '0;
        slot_vld = '0;
        next_ptr = start_ptr;
        cnt      = 0;
        idx      = '0;

        // Walk the requesters starting at start_ptr, wrapping modulo NUM_FU,
        // and hand out slots in the order requesters are met.
        for (int off = 0; off < NUM_FU; off++) begin
            idx = FU_IDX_W'((int'(start_ptr) + off) % NUM_FU);
            if (req[idx] && (cnt < NUM_CDB)) begin
                grant[idx] = 1'b1;
                // Constant slot loop keeps the slot select a compile-time index.
                for (int k = 0; k < NUM_CDB; k++) begin
                    if (k == cnt) begin
                        slot_idx[k] = idx;
                        slot_vld[k] = 1'b1;
                    end
                end
                next_ptr = FU_IDX_W'((int'(idx) + 1) % NUM_FU);
                cnt      = cnt + 1;
            end
        end

        grant_cnt = CNT_W'(cnt);
    end

endmodule

// File: rtl/cdb_arbiter.sv
// ----------------------------------------------------------------------------
// cdb_arbiter
// Shares NUM_CDB common-data-bus ports among NUM_FU functional units.
// Grants are issued combinationally in the request cycle; granted packets
// are broadcast from a register stage one cycle later.
//   clock : rising-edge clock
//   reset : synchronous, active-low (0 = in reset); grants are masked
//           while it is low
//   bus   : cdb_arbiter_if slave port (requests, packets, grants,
//           registered CDB packets, rr_ptr, grant_count)
// ----------------------------------------------------------------------------
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU   = NUM_FU_DEF,
    parameter int NUM_CDB  = NUM_CDB_DEF,
    parameter int FU_IDX_W = $clog2(NUM_FU)
) (
    input  logic          clock,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(NUM_CDB + 1);

    logic [NUM_FU-1:0]                req_p0;
    logic [NUM_FU-1:0]                grant_p0;
    logic [NUM_CDB-1:0][FU_IDX_W-1:0] slot_idx_p0;
    logic [NUM_CDB-1:0]               slot_vld_p0;
    logic [FU_IDX_W-1:0]              next_ptr_p0;
    logic [CNT_W-1:0]                 grant_cnt_p0;

    cdb_reg_packet_t [NUM_CDB-1:0]    cdb_pkt_p1;
    logic [FU_IDX_W-1:0]              rr_ptr_q;
    logic [31:0]                      grant_count_q;

    // Masking requests during reset zeroes the grants and keeps the
    // pointer/counter inputs quiet without a second gating point.
    assign req_p0 = reset ? bus.fu_req : '0;

    cdb_arbiter_rr_multi_select #(
        .NUM_FU   (NUM_FU),
        .NUM_CDB  (NUM_CDB),
        .FU_IDX_W (FU_IDX_W),
        .CNT_W    (CNT_W)
    ) u_select (
        .req       (req_p0),
        .start_ptr (rr_ptr_q),
        .grant     (grant_p0),
        .slot_idx  (slot_idx_p0),
        .slot_vld  (slot_vld_p0),
        .next_ptr  (next_ptr_p0),
        .grant_cnt (grant_cnt_p0)
    );

    assign bus.fu_grant = grant_p0;

    // ---- p0 -> p1 : capture granted packets into the broadcast stage ----
    always_ff @(posedge clock) begin
        if (!reset) begin
            cdb_pkt_p1 <= '0;
        end else begin
            for (int k = 0; k < NUM_CDB; k++) begin
                if (slot_vld_p0[k]) begin
                    cdb_pkt_p1[k].valid          <= 1'b1;
                    cdb_pkt_p1[k].result         <= bus.fu_packet[slot_idx_p0[k]].result;
                    cdb_pkt_p1[k].completing_reg <= bus.fu_packet[slot_idx_p0[k]].completing_reg;
                end else begin
                    // Empty slot: only valid drops, data fields keep last value.
                    cdb_pkt_p1[k].valid <= 1'b0;
                end
            end
        end
    end

    // Pointer moves past the last winner; it holds when nothing was granted.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr_q      <= '0;
            grant_count_q <= '0;
        end else begin
            if (|grant_p0) begin
                rr_ptr_q <= next_ptr_p0;
            end
            grant_count_q <= grant_count_q + 32'(grant_cnt_p0);
        end
    end

    assign bus.cdb_packets = cdb_pkt_p1;
    assign bus.rr_ptr      = rr_ptr_q;
    assign bus.grant_count = grant_count_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NF = 4;
    localparam int NC = 2;

    logic clock = 1'b0;
    logic reset;

    cdb_arbiter_if #(.NUM_FU(NF), .NUM_CDB(NC)) bus ();

    cdb_arbiter #(.NUM_FU(NF), .NUM_CDB(NC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Stimulus-side packet contents per FU.
    logic [31:0]          p_res [NF];
    logic [REG_IDX_W-1:0] p_reg [NF];
    logic                 p_val [NF];

    // Reference model state.
    int              m_ptr;
    logic [31:0]     m_gcnt;
    cdb_reg_packet_t m_slot [NC];
    int              m_order [$];
    logic [NF-1:0]   m_grant;

    logic [NF-1:0]   obs_grant;
    logic [NF-1:0]   cur_req;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requesters met in rotated order from the pointer; the first NC win.
    task automatic model_pick(input logic rst_n, input logic [NF-1:0] req);
        int rot [$];
        m_order.delete();
        m_grant = '0;
        if (rst_n) begin
            for (int n = 0; n < NF; n++) rot.push_back((m_ptr + n) % NF);
            foreach (rot[j]) if (req[rot[j]]) m_order.push_back(rot[j]);
            while (m_order.size() > NC) void'(m_order.pop_back());
            foreach (m_order[j]) m_grant[m_order[j]] = 1'b1;
        end
    endtask

    task automatic model_edge(input logic rst_n);
        if (!rst_n) begin
            m_ptr  = 0;
            m_gcnt = 0;
            for (int k = 0; k < NC; k++) m_slot[k] = '0;
        end else begin
            for (int k = 0; k < NC; k++) begin
                if (k < m_order.size()) begin
                    m_slot[k].valid          = 1'b1;
                    m_slot[k].result         = p_res[m_order[k]];
                    m_slot[k].completing_reg = p_reg[m_order[k]];
                end else begin
                    m_slot[k].valid = 1'b0;
                end
            end
            if (m_order.size() > 0) m_ptr = (m_order[m_order.size()-1] + 1) % NF;
            m_gcnt = m_gcnt + 32'(m_order.size());
        end
    endtask

    // One clock: drive, check the combinational grant, clock, check registers.
    task automatic cycle(input logic rst_n, input logic [NF-1:0] req);
        reset      = rst_n;
        bus.fu_req = req;
        for (int i = 0; i < NF; i++) begin
            bus.fu_packet[i].valid          = p_val[i];
            bus.fu_packet[i].result         = p_res[i];
            bus.fu_packet[i].completing_reg = p_reg[i];
        end
        #1;
        model_pick(rst_n, req);
        obs_grant = bus.fu_grant;
        chk("fu_grant", 64'(obs_grant), 64'(m_grant));
        model_edge(rst_n);
        @(posedge clock);
        #1;
        chk("rr_ptr", 64'(bus.rr_ptr), 64'(m_ptr));
        chk("grant_count", 64'(bus.grant_count), 64'(m_gcnt));
        for (int k = 0; k < NC; k++)
            chk($sformatf("cdb_packets[%0d]", k), 64'(bus.cdb_packets[k]), 64'(m_slot[k]));
    endtask

    initial begin
        for (int i = 0; i < NF; i++) begin
            p_res[i] = 32'h1000_0000 + 32'(i);
            p_reg[i] = REG_IDX_W'(i + 8);
            p_val[i] = 1'b0;
        end
        m_ptr  = 0;
        m_gcnt = 0;
        for (int k = 0; k < NC; k++) m_slot[k] = '0;
        reset      = 1'b0;
        bus.fu_req = '0;

        // Reset held two cycles with everyone requesting.
        cycle(1'b0, 4'b1111);
        chk("reset_grant0", 64'(obs_grant), 64'h0);
        cycle(1'b0, 4'b1111);
        chk("reset_grant1", 64'(obs_grant), 64'h0);
        chk("reset_ptr", 64'(bus.rr_ptr), 64'h0);
        chk("reset_count", 64'(bus.grant_count), 64'h0);
        chk("reset_v0", 64'(bus.cdb_packets[0].valid), 64'h0);
        chk("reset_v1", 64'(bus.cdb_packets[1].valid), 64'h0);

        // Full contention from pointer 0.
        cycle(1'b1, 4'b1111);
        chk("cont_g0", 64'(obs_grant), 64'h3);
        chk("cont_p0", 64'(bus.rr_ptr), 64'd2);
        cycle(1'b1, 4'b1111);
        chk("cont_g1", 64'(obs_grant), 64'hC);
        chk("cont_p1", 64'(bus.rr_ptr), 64'd0);
        cycle(1'b1, 4'b1111);
        chk("cont_g2", 64'(obs_grant), 64'h3);
        chk("cont_p2", 64'(bus.rr_ptr), 64'd2);
        cycle(1'b1, 4'b1111);
        chk("cont_g3", 64'(obs_grant), 64'hC);
        chk("cont_p3", 64'(bus.rr_ptr), 64'd0);
        chk("cont_count", 64'(bus.grant_count), 64'd8);

        // Single request; packet valid bit low to show the arbiter owns valid.
        p_res[2] = 32'hDEAD_BEEF;
        p_reg[2] = REG_IDX_W'(21);
        cycle(1'b1, 4'b0100);
        chk("basic_grant", 64'(obs_grant), 64'h4);
        chk("basic_v0", 64'(bus.cdb_packets[0].valid), 64'h1);
        chk("basic_res", 64'(bus.cdb_packets[0].result), 64'hDEAD_BEEF);
        chk("basic_reg", 64'(bus.cdb_packets[0].completing_reg), 64'd21);
        chk("basic_v1", 64'(bus.cdb_packets[1].valid), 64'h0);
        chk("basic_ptr", 64'(bus.rr_ptr), 64'd3);

        // Wrap from pointer 3.
        p_res[3] = 32'h3333_0003;
        p_res[0] = 32'h0000_0AAA;
        cycle(1'b1, 4'b1001);
        chk("wrap_grant", 64'(obs_grant), 64'h9);
        chk("wrap_slot0", 64'(bus.cdb_packets[0].result), 64'h3333_0003);
        chk("wrap_slot1", 64'(bus.cdb_packets[1].result), 64'h0000_0AAA);
        chk("wrap_ptr", 64'(bus.rr_ptr), 64'd1);

        // Park the pointer at 0, then let the mult lose one round.
        cycle(1'b1, 4'b1000);
        chk("park_ptr", 64'(bus.rr_ptr), 64'd0);
        p_res[FU_MULT] = 32'(7 * 6);
        p_val[FU_MULT] = 1'b1;
        cycle(1'b1, 4'b0111);
        chk("mult_lose", 64'(obs_grant[FU_MULT]), 64'h0);
        cycle(1'b1, 4'b0100);
        chk("mult_win", 64'(obs_grant), 64'h4);
        chk("mult_res", 64'(bus.cdb_packets[0].result), 64'd42);
        chk("mult_v0", 64'(bus.cdb_packets[0].valid), 64'h1);
        chk("mult_v1", 64'(bus.cdb_packets[1].valid), 64'h0);

        // Idle: no grant, pointer holds, slots empty.
        cycle(1'b1, 4'b0000);
        chk("idle_grant", 64'(obs_grant), 64'h0);
        chk("idle_v0", 64'(bus.cdb_packets[0].valid), 64'h0);
        chk("idle_ptr", 64'(bus.rr_ptr), 64'd3);

        // Reset in the middle of traffic.
        cycle(1'b1, 4'b0001);
        chk("pre_rst_v0", 64'(bus.cdb_packets[0].valid), 64'h1);
        cycle(1'b0, 4'b1111);
        chk("mid_rst_grant", 64'(obs_grant), 64'h0);
        chk("mid_rst_v0", 64'(bus.cdb_packets[0].valid), 64'h0);
        chk("mid_rst_ptr", 64'(bus.rr_ptr), 64'd0);
        cycle(1'b1, 4'b0010);
        chk("resume_grant", 64'(obs_grant), 64'h2);
        chk("resume_ptr", 64'(bus.rr_ptr), 64'd2);

        // Randomized traffic; losers hold request and packet.
        cur_req   = '0;
        obs_grant = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NF; i++) begin
                if (!(cur_req[i] && !obs_grant[i])) begin
                    cur_req[i] = 1'($urandom_range(0, 3) != 0);
                    p_res[i]   = $urandom;
                    p_reg[i]   = REG_IDX_W'($urandom);
                    p_val[i]   = 1'($urandom_range(0, 1));
                end
            end
            cycle(($urandom_range(0, 49) != 0), cur_req);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
